// File: rtl/tl_reg_slave.sv
// -----------------------------------------------------------------------------
// tl_reg_slave
// TileLink-UL slave endpoint fed by an A/D buffer stage. It services Put/Get
// requests against a flat bank of NREGS 32-bit software registers and returns
// one D-channel response per accepted request, one cycle after acceptance.
// Throughput is one request per cycle while the D side keeps d_ready high.
//
// Optional feature macro: TL_REG_SLAVE_ERR_EN
//   defined   : erroneous requests are denied (d_denied=1, d_data=0, no write);
//               Get/unsupported errors also raise d_corrupt.
//   undefined : d_denied/d_corrupt stay 0; erroneous Puts are dropped and
//               erroneous Gets return 0 (an in-range oversize Get still reads).
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   a_valid/a_ready     A-channel handshake (a_ready is combinational)
//   a_opcode            0 PutFull, 1 PutPartial, 4 Get, others unsupported
//   a_param             ignored
//   a_size              log2 bytes, legal 0..2
//   a_source            request ID, echoed on d_source
//   a_address           byte address, word index = a_address[..:2]
//   a_mask, a_data      byte-lane enables and write data for Puts
//   d_valid/d_ready     D-channel handshake
//   d_opcode            0 AccessAck, 1 AccessAckData
//   d_param             constant 0
//   d_size, d_source    captured a_size / a_source
//   d_denied, d_corrupt error indications
//   d_data              read data (0 for AccessAck and denied responses)
//   regs                register bank, register i at [32*i +: 32]
// -----------------------------------------------------------------------------
module tl_reg_slave #(
  parameter int NREGS  = 8,
  parameter int ADDR_W = 14,
  parameter int SRC_W  = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [2:0]            a_opcode,
  input  logic [2:0]            a_param,
  input  logic [3:0]            a_size,
  input  logic [SRC_W-1:0]      a_source,
  input  logic [ADDR_W-1:0]     a_address,
  input  logic [3:0]            a_mask,
  input  logic [31:0]           a_data,
  output logic                  d_valid,
  input  logic                  d_ready,
  output logic [2:0]            d_opcode,
  output logic [1:0]            d_param,
  output logic [3:0]            d_size,
  output logic [SRC_W-1:0]      d_source,
  output logic                  d_denied,
  output logic [31:0]           d_data,
  output logic                  d_corrupt,
  output logic [NREGS*32-1:0]   regs
);

  localparam int LOG2N = $clog2(NREGS);
  localparam int IDX_W = (LOG2N > 0) ? LOG2N : 1;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_ACK         = 3'd0;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  // The response-pending flag doubles as the state: RESP means d_valid is up.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [31:0]       reg_q [NREGS];
  logic              accept;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] addr_high;
  logic              in_range;
  logic              is_put;
  logic              is_get;
  logic              err;
  logic              do_write;
  logic [31:0]       rd_word;
  logic [2:0]        rsp_opcode;
  logic [31:0]       rsp_data;
  logic              rsp_denied;
  logic              rsp_corrupt;

  logic [2:0]        d_opcode_q;
  logic [3:0]        d_size_q;
  logic [SRC_W-1:0]  d_source_q;
  logic [31:0]       d_data_q;
  logic              d_denied_q;
  logic              d_corrupt_q;

  // Bits that carry no meaning for this endpoint.
  logic unused_bits;
  assign unused_bits = ^{a_param, a_address[1:0]};

  // Request decode. Any address bit above the word-index field makes the
  // request out of range; the low two byte-offset bits never matter.
  assign accept    = a_valid & a_ready;
  assign idx       = a_address[2 +: IDX_W];
  assign addr_high = a_address >> (2 + LOG2N);
  assign in_range  = (addr_high == '0);
  assign is_put    = (a_opcode == OP_PUT_FULL) | (a_opcode == OP_PUT_PARTIAL);
  assign is_get    = (a_opcode == OP_GET);
  assign err       = ~in_range | (a_size > 4'd2) | ~(is_put | is_get);
  assign do_write  = is_put & ~err;
  assign rd_word   = in_range ? reg_q[idx] : 32'h0;

  // Response contents computed from the request being accepted this cycle.
  // Reads see the register value before this edge, which already includes
  // any write accepted on an earlier edge.
  always_comb begin
    rsp_opcode  = is_put ? OP_ACK : OP_ACK_DATA;
    rsp_data    = 32'h0;
    rsp_denied  = 1'b0;
    rsp_corrupt = 1'b0;
`ifdef TL_REG_SLAVE_ERR_EN
    rsp_denied  = err;
    rsp_corrupt = err & ~is_put;
    if (is_get && !err) begin
      rsp_data = rd_word;
    end
`else
    if (is_get && in_range) begin
      rsp_data = rd_word;
    end
`endif
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a new accept always leaves a response pending; otherwise a
  // pending response survives only while the consumer stalls.
  always_comb begin
    state_d = IDLE;
    if (accept) begin
      state_d = RESP;
    end else if (state_q == RESP && !d_ready) begin
      state_d = RESP;
    end
  end

  // Handshake outputs. a_ready looks only at the D side so that the upstream
  // buffer never sees a combinational path from its own a_valid.
  always_comb begin
    d_valid = (state_q == RESP);
    a_ready = ~d_valid | d_ready;
  end

  // D-channel field capture; fields only change on an accept, so they stay
  // stable while the response is stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      d_opcode_q  <= 3'd0;
      d_size_q    <= 4'd0;
      d_source_q  <= '0;
      d_data_q    <= 32'h0;
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
    end else if (accept) begin
      d_opcode_q  <= rsp_opcode;
      d_size_q    <= a_size;
      d_source_q  <= a_source;
      d_data_q    <= rsp_data;
      d_denied_q  <= rsp_denied;
      d_corrupt_q <= rsp_corrupt;
    end
  end

  // Register bank write; PutFull and PutPartial are both gated by a_mask.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        reg_q[i] <= 32'h0;
      end
    end else if (accept && do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (a_mask[b]) begin
          reg_q[idx][8*b +: 8] <= a_data[8*b +: 8];
        end
      end
    end
  end

  assign d_opcode  = d_opcode_q;
  assign d_param   = 2'd0;
  assign d_size    = d_size_q;
  assign d_source  = d_source_q;
  assign d_data    = d_data_q;
  assign d_denied  = d_denied_q;
  assign d_corrupt = d_corrupt_q;

  for (genvar g = 0; g < NREGS; g++) begin : g_regs_flat
    assign regs[32*g +: 32] = reg_q[g];
  end

endmodule
